// File: rtl/reaction_round_ctrl.sv
// Multi-round reaction-time game core: countdown, LFSR-random wait, GO lamp, measured reaction.
// Latency: all outputs registered, one cycle after the causing input; no backpressure (strobe/pulse driven).
module reaction_round_ctrl #(
    parameter int CNT_W     = 9,
    parameter int TIMEOUT   = 300,
    parameter int DELAY_MIN = 100,
    parameter int COUNTDOWN = 5,
    parameter int ROUNDS    = 3,
    parameter int SCORE_W   = 12
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               tick,
    input  logic               enable,
    input  logic               start,
    input  logic               react,
    input  logic [CNT_W-1:0]   seed,
    output logic [2:0]         state_o,
    output logic               go,
    output logic [2:0]         countdown,
    output logic [3:0]         round_idx,
    output logic [CNT_W-1:0]   last_time,
    output logic [1:0]         last_result,
    output logic [SCORE_W-1:0] total,
    output logic [CNT_W-1:0]   best
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ARM    = 3'd1,
        S_WAIT   = 3'd2,
        S_GO     = 3'd3,
        S_RESULT = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] TO_C   = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] TO_M1  = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] DMIN_C = CNT_W'(DELAY_MIN);
    localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);
    localparam logic [2:0]       CD_C   = 3'(COUNTDOWN);
    localparam logic [3:0]       LAST_R = 4'(ROUNDS - 1);

    state_t             state_q;
    logic [8:0]         lfsr_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               go_q;
    logic [2:0]         cd_q;
    logic [3:0]         round_q;
    logic [CNT_W-1:0]   last_time_q;
    logic [1:0]         last_result_q;
    logic [SCORE_W-1:0] total_q;
    logic [CNT_W-1:0]   best_q;

    logic [8:0]         lfsr_d;
    logic [8:0]         seed9;
    logic [8:0]         seed_lfsr;
    logic [CNT_W-1:0]   lfsr_val;
    logic [CNT_W-1:0]   delay_val;

    // x^9 + x^5 + 1 Fibonacci form; the all-zero state is unreachable from a nonzero load
    assign lfsr_d    = {lfsr_q[7:0], lfsr_q[8] ^ lfsr_q[4]};
    assign seed9     = 9'(seed);
    assign seed_lfsr = (seed9 == 9'd0) ? 9'd1 : seed9;
    assign lfsr_val  = CNT_W'(lfsr_q);
    assign delay_val = (lfsr_val < DMIN_C) ? (lfsr_val + DMIN_C) : lfsr_val;

    function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                   input logic [CNT_W-1:0]   b);
        logic [SCORE_W:0] s;
        s = {1'b0, a} + (SCORE_W + 1)'(b);
        return s[SCORE_W] ? {SCORE_W{1'b1}} : s[SCORE_W-1:0];
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            lfsr_q        <= 9'd1;
            cnt_q         <= '0;
            go_q          <= 1'b0;
            cd_q          <= 3'd0;
            round_q       <= 4'd0;
            last_time_q   <= '0;
            last_result_q <= 2'b00;
            total_q       <= '0;
            best_q        <= '1;
        end else if (!enable) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            go_q          <= 1'b0;
            cd_q          <= 3'd0;
            round_q       <= 4'd0;
            last_time_q   <= '0;
            last_result_q <= 2'b00;
            total_q       <= '0;
        end else begin
            if (tick && state_q != S_IDLE)
                lfsr_q <= lfsr_d;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        lfsr_q        <= seed_lfsr;
                        state_q       <= S_ARM;
                        cd_q          <= CD_C;
                        round_q       <= 4'd0;
                        total_q       <= '0;
                        last_result_q <= 2'b00;
                    end
                end
                S_ARM: begin
                    if (tick) begin
                        if (cd_q == 3'd1) begin
                            state_q <= S_WAIT;
                            cd_q    <= 3'd0;
                            cnt_q   <= delay_val;
                        end else begin
                            cd_q <= cd_q - 3'd1;
                        end
                    end
                end
                S_WAIT: begin
                    // a false start wins over a tick that would have lit the lamp
                    if (react) begin
                        state_q       <= S_RESULT;
                        last_result_q <= 2'b10;
                        last_time_q   <= TO_C;
                        total_q       <= sat_add(total_q, TO_C);
                    end else if (tick) begin
                        if (cnt_q == ONE_C) begin
                            state_q <= S_GO;
                            go_q    <= 1'b1;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q - ONE_C;
                        end
                    end
                end
                S_GO: begin
                    if (react) begin
                        state_q       <= S_RESULT;
                        go_q          <= 1'b0;
                        last_result_q <= 2'b01;
                        last_time_q   <= cnt_q;
                        total_q       <= sat_add(total_q, cnt_q);
                        if (cnt_q < best_q)
                            best_q <= cnt_q;
                    end else if (tick) begin
                        if (cnt_q == TO_M1) begin
                            state_q       <= S_RESULT;
                            go_q          <= 1'b0;
                            last_result_q <= 2'b11;
                            last_time_q   <= TO_C;
                            total_q       <= sat_add(total_q, TO_C);
                        end else begin
                            cnt_q <= cnt_q + ONE_C;
                        end
                    end
                end
                S_RESULT: begin
                    if (start) begin
                        if (round_q == LAST_R) begin
                            state_q <= S_DONE;
                        end else begin
                            round_q <= round_q + 4'd1;
                            state_q <= S_ARM;
                            cd_q    <= CD_C;
                        end
                    end
                end
                S_DONE: begin
                    // new game keeps best and continues the LFSR sequence
                    if (start) begin
                        state_q       <= S_ARM;
                        cd_q          <= CD_C;
                        round_q       <= 4'd0;
                        total_q       <= '0;
                        last_result_q <= 2'b00;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign state_o     = state_q;
    assign go          = go_q;
    assign countdown   = cd_q;
    assign round_idx   = round_q;
    assign last_time   = last_time_q;
    assign last_result = last_result_q;
    assign total       = total_q;
    assign best        = best_q;

endmodule

// File: tb/tb_reaction_round_ctrl.sv
// Directed bench for reaction_round_ctrl with default parameters; own LFSR model predicts wait lengths.
module tb_reaction_round_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tick = 1'b0;
    logic        enable = 1'b0;
    logic        start = 1'b0;
    logic        react = 1'b0;
    logic [8:0]  seed = 9'd0;
    logic [2:0]  state_o;
    logic        go;
    logic [2:0]  countdown;
    logic [3:0]  round_idx;
    logic [8:0]  last_time;
    logic [1:0]  last_result;
    logic [11:0] total;
    logic [8:0]  best;

    int checks = 0;
    int failures = 0;
    logic [8:0] m_lfsr = 9'd1;
    bit m_active = 1'b0;
    int d, n;

    reaction_round_ctrl dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .enable(enable), .start(start),
        .react(react), .seed(seed), .state_o(state_o), .go(go), .countdown(countdown),
        .round_idx(round_idx), .last_time(last_time), .last_result(last_result),
        .total(total), .best(best)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [8:0] lfsr_step(input logic [8:0] l);
        return {l[7:0], l[8] ^ l[4]};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        if (m_active) m_lfsr = lfsr_step(m_lfsr);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic pulse_react();
        react = 1'b1;
        cyc();
        react = 1'b0;
    endtask

    // ARM lasts COUNTDOWN ticks; the wait length comes from the LFSR before the last ARM tick
    task automatic to_wait(output int dexp);
        repeat (4) pulse_tick();
        dexp = (m_lfsr < 9'd100) ? int'(m_lfsr) + 100 : int'(m_lfsr);
        pulse_tick();
    endtask

    task automatic run_wait(output int cnt);
        cnt = 0;
        while (state_o == 3'd2 && cnt < 700) begin
            pulse_tick();
            cnt++;
        end
    endtask

    task automatic hit_round(input int t, input bit same_tick);
        int dd, nn;
        to_wait(dd);
        run_wait(nn);
        check_eq("wait_len", nn, dd);
        check_eq("go_on", go, 1);
        repeat (t) pulse_tick();
        react = 1'b1;
        if (same_tick) tick = 1'b1;
        cyc();
        react = 1'b0;
        if (same_tick) begin
            tick = 1'b0;
            m_lfsr = lfsr_step(m_lfsr);
        end
        check_eq("hit_res", last_result, 1);
        check_eq("hit_time", last_time, t);
    endtask

    initial begin
        // reset values
        #12;
        check_eq("rst_state", state_o, 0);
        check_eq("rst_best", best, 9'h1FF);
        check_eq("rst_total", total, 0);
        check_eq("rst_go", go, 0);
        rst_n = 1'b1;
        enable = 1'b1;
        cyc();

        // game A, round 0: seed 0x0A5 gives wait 187, hit at 40
        seed = 9'h0A5;
        pulse_start();
        m_lfsr = 9'h0A5;
        m_active = 1'b1;
        check_eq("arm_state", state_o, 1);
        check_eq("arm_cd", countdown, 5);
        repeat (4) pulse_tick();
        check_eq("arm_cd1", countdown, 1);
        pulse_react();
        check_eq("arm_react_ign", state_o, 1);
        d = (m_lfsr < 9'd100) ? int'(m_lfsr) + 100 : int'(m_lfsr);
        pulse_tick();
        check_eq("wait_state", state_o, 2);
        check_eq("wait_cd0", countdown, 0);
        run_wait(n);
        check_eq("wait_len_a", n, 187);
        check_eq("wait_len_model", n, d);
        check_eq("go_state", state_o, 3);
        check_eq("go_on", go, 1);
        repeat (40) pulse_tick();
        pulse_react();
        check_eq("a0_state", state_o, 4);
        check_eq("a0_go", go, 0);
        check_eq("a0_res", last_result, 1);
        check_eq("a0_time", last_time, 40);
        check_eq("a0_total", total, 40);
        check_eq("a0_best", best, 40);
        pulse_tick();
        check_eq("result_tick_ign", state_o, 4);

        // round 1: false start
        pulse_start();
        check_eq("a1_round", round_idx, 1);
        check_eq("a1_cd", countdown, 5);
        to_wait(d);
        repeat (10) pulse_tick();
        pulse_start();
        check_eq("wait_start_ign", state_o, 2);
        pulse_react();
        check_eq("a1_state", state_o, 4);
        check_eq("a1_res", last_result, 2);
        check_eq("a1_time", last_time, 300);
        check_eq("a1_total", total, 340);
        check_eq("a1_go", go, 0);

        // round 2: timeout after exactly 300 GO ticks
        pulse_start();
        check_eq("a2_round", round_idx, 2);
        to_wait(d);
        run_wait(n);
        check_eq("a2_wait", n, d);
        n = 0;
        while (state_o == 3'd3 && n < 400) begin
            pulse_tick();
            n++;
        end
        check_eq("a2_go_len", n, 300);
        check_eq("a2_res", last_result, 3);
        check_eq("a2_time", last_time, 300);
        check_eq("a2_total", total, 640);
        pulse_start();
        check_eq("a_done", state_o, 5);
        pulse_tick();
        check_eq("done_tick_ign", state_o, 5);

        // game B: fresh game from DONE, hits 50/30/70
        pulse_start();
        check_eq("b_state", state_o, 1);
        check_eq("b_round", round_idx, 0);
        check_eq("b_total", total, 0);
        check_eq("b_lres", last_result, 0);
        check_eq("b_best_kept", best, 40);
        hit_round(50, 1'b0);
        check_eq("b0_best", best, 40);
        pulse_start();
        hit_round(30, 1'b1);
        check_eq("b1_best", best, 30);
        check_eq("b1_total", total, 80);
        pulse_start();
        hit_round(70, 1'b0);
        check_eq("b2_total", total, 150);
        pulse_start();
        check_eq("b_done", state_o, 5);
        check_eq("b_best", best, 30);
        pulse_start();
        check_eq("c_state", state_o, 1);
        check_eq("c_best", best, 30);

        // enable low mid-GO
        to_wait(d);
        run_wait(n);
        check_eq("c_wait", n, d);
        repeat (5) pulse_tick();
        enable = 1'b0;
        cyc();
        m_active = 1'b0;
        check_eq("en_state", state_o, 0);
        check_eq("en_go", go, 0);
        check_eq("en_total", total, 0);
        check_eq("en_round", round_idx, 0);
        check_eq("en_best", best, 30);
        enable = 1'b1;
        cyc();

        // seed 0 loads 1: LFSR reaches 16 after ARM, wait 116; then async reset mid-WAIT
        seed = 9'd0;
        pulse_start();
        m_lfsr = 9'd1;
        m_active = 1'b1;
        to_wait(d);
        check_eq("s0_state", state_o, 2);
        n = 0;
        while (state_o == 3'd2 && n < 700) begin
            pulse_tick();
            n++;
        end
        check_eq("s0_wait", n, 116);
        repeat (20) pulse_tick();
        pulse_react();
        check_eq("s0_time", last_time, 20);
        pulse_start();
        to_wait(d);
        repeat (10) pulse_tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_state", state_o, 0);
        check_eq("arst_best", best, 9'h1FF);
        check_eq("arst_total", total, 0);
        check_eq("arst_round", round_idx, 0);
        cyc();
        rst_n = 1'b1;
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
